// File: rtl/soc_system_lcd_touch_int_gen_pkg.sv
// Shared definitions for the touch interrupt generator: register map and FSM state type.
package soc_system_lcd_touch_int_gen_pkg;
  `include "soc_system_lcd_touch_int_gen_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_ASSERT = ST_ASSERT,
    S_GAP    = ST_GAP
  } state_t;
endpackage

// File: rtl/soc_system_lcd_pulse_timer.sv
// Loadable down-counter; holds at zero until reloaded. Shared by the pulse and gap phases.
module soc_system_lcd_pulse_timer #(
  parameter int WIDTH_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [WIDTH_W-1:0] val,
  output logic               zero
);
  logic [WIDTH_W-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - WIDTH_W'(1);
    end
  end

  assign zero = (count_reg == '0);
endmodule

// File: rtl/soc_system_lcd_touch_int_gen_defs.vh
// Register map, CTRL/TRIG bit positions and FSM encodings for the touch interrupt generator.
`ifndef SOC_SYSTEM_LCD_TOUCH_INT_GEN_DEFS_VH
`define SOC_SYSTEM_LCD_TOUCH_INT_GEN_DEFS_VH

localparam logic [1:0] ADDR_CTRL  = 2'd0;
localparam logic [1:0] ADDR_WIDTH = 2'd1;
localparam logic [1:0] ADDR_MASK  = 2'd2;
localparam logic [1:0] ADDR_TRIG  = 2'd3;

localparam int CTRL_EN_BIT   = 0;
localparam int CTRL_POL_BIT  = 1;
localparam int CTRL_BUSY_BIT = 2;
localparam int CTRL_PEND_LSB = 8;

localparam int TRIG_ENQ_BIT  = 0;
localparam int TRIG_CLR_BIT  = 1;
localparam int TRIG_DONE_BIT = 0;
localparam int TRIG_OVF_BIT  = 1;

localparam logic [1:0] ST_IDLE   = 2'd0;
localparam logic [1:0] ST_ASSERT = 2'd1;
localparam logic [1:0] ST_GAP    = 2'd2;

`endif

// File: rtl/soc_system_lcd_touch_int_gen.sv
// Avalon-MM slave that emits queued, width-programmable interrupt pulses on out_port with a
// fixed inactive gap after each pulse, and raises irq when a pulse completes.
module soc_system_lcd_touch_int_gen
  import soc_system_lcd_touch_int_gen_pkg::*;
#(
  parameter int WIDTH_W    = 16,
  parameter int PEND_W     = 4,
  parameter int GAP_CYCLES = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic        out_port
);
  localparam logic [WIDTH_W-1:0] GAP_LOAD = WIDTH_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0]  PEND_MAX = '1;

  state_t             state_reg, state_next;
  logic               en_reg, en_next;
  logic               pol_reg, pol_next;
  logic [WIDTH_W-1:0] width_reg, width_next;
  logic               mask_reg, mask_next;
  logic [PEND_W-1:0]  pending_reg, pending_next;
  logic               done_reg, done_next;
  logic               ovf_reg, ovf_next;
  logic               out_port_reg, out_port_next;
  logic [31:0]        readdata_reg, readdata_next;

  logic               wr, ctrl_wr, trig_wr, abort, enq, clr, deq, done_set;
  logic               tmr_load, tmr_zero;
  logic [WIDTH_W-1:0] tmr_val;
  logic               unused_writedata;

  assign unused_writedata = ^writedata;

  assign wr      = chipselect & ~write_n;
  assign ctrl_wr = wr && (address == ADDR_CTRL);
  assign trig_wr = wr && (address == ADDR_TRIG);
  assign abort   = ctrl_wr && !writedata[CTRL_EN_BIT];
  assign enq     = trig_wr && writedata[TRIG_ENQ_BIT];
  assign clr     = trig_wr && writedata[TRIG_CLR_BIT];

  // Control fields take effect in the cycle they are written so the idle level and aborts
  // show on out_port one cycle after the write.
  always_comb begin
    en_next    = en_reg;
    pol_next   = pol_reg;
    width_next = width_reg;
    mask_next  = mask_reg;
    if (ctrl_wr) begin
      en_next  = writedata[CTRL_EN_BIT];
      pol_next = writedata[CTRL_POL_BIT];
    end
    if (wr && (address == ADDR_WIDTH)) width_next = writedata[WIDTH_W-1:0];
    if (wr && (address == ADDR_MASK))  mask_next  = writedata[0];
  end

  always_comb begin
    state_next = state_reg;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    deq        = 1'b0;
    done_set   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (en_next && (pending_reg != '0)) begin
          state_next = S_ASSERT;
          deq        = 1'b1;
          tmr_load   = 1'b1;
          tmr_val    = (width_reg == '0) ? '0 : width_reg - WIDTH_W'(1);
        end
      end
      S_ASSERT: begin
        if (tmr_zero) begin
          state_next = S_GAP;
          tmr_load   = 1'b1;
          tmr_val    = GAP_LOAD;
          done_set   = 1'b1;
        end
      end
      S_GAP: begin
        if (tmr_zero) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
      tmr_load   = 1'b1;
      tmr_val    = '0;
      deq        = 1'b0;
      done_set   = 1'b0;
    end
  end

  // Enqueue and dequeue in the same cycle cancel; only a saturating enqueue flags overflow.
  always_comb begin
    pending_next = pending_reg;
    ovf_next     = clr ? 1'b0 : ovf_reg;
    if (abort) begin
      pending_next = '0;
    end else if (enq && !deq) begin
      if (pending_reg == PEND_MAX) ovf_next = 1'b1;
      else                         pending_next = pending_reg + PEND_W'(1);
    end else if (deq && !enq) begin
      pending_next = pending_reg - PEND_W'(1);
    end
    done_next     = done_set ? 1'b1 : (clr ? 1'b0 : done_reg);
    out_port_next = (state_next == S_ASSERT) ? ~pol_next : pol_next;
  end

  always_comb begin
    readdata_next = '0;
    case (address)
      ADDR_CTRL: begin
        readdata_next[CTRL_EN_BIT]              = en_reg;
        readdata_next[CTRL_POL_BIT]             = pol_reg;
        readdata_next[CTRL_BUSY_BIT]            = (state_reg != S_IDLE);
        readdata_next[CTRL_PEND_LSB +: PEND_W]  = pending_reg;
      end
      ADDR_WIDTH: readdata_next[WIDTH_W-1:0] = width_reg;
      ADDR_MASK:  readdata_next[0]           = mask_reg;
      default: begin
        readdata_next[TRIG_DONE_BIT] = done_reg;
        readdata_next[TRIG_OVF_BIT]  = ovf_reg;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= S_IDLE;
      en_reg       <= 1'b0;
      pol_reg      <= ACTIVE_LOW;
      width_reg    <= WIDTH_W'(1);
      mask_reg     <= 1'b0;
      pending_reg  <= '0;
      done_reg     <= 1'b0;
      ovf_reg      <= 1'b0;
      out_port_reg <= ACTIVE_LOW;
      readdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      en_reg       <= en_next;
      pol_reg      <= pol_next;
      width_reg    <= width_next;
      mask_reg     <= mask_next;
      pending_reg  <= pending_next;
      done_reg     <= done_next;
      ovf_reg      <= ovf_next;
      out_port_reg <= out_port_next;
      readdata_reg <= readdata_next;
    end
  end

  soc_system_lcd_pulse_timer #(
    .WIDTH_W (WIDTH_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .val     (tmr_val),
    .zero    (tmr_zero)
  );

  assign readdata = readdata_reg;
  assign irq      = done_reg & mask_reg;
  assign out_port = out_port_reg;
endmodule

// File: tb/tb_soc_system_lcd_touch_int_gen.sv
// Directed bench for soc_system_lcd_touch_int_gen: pulse width, gap, queueing, abort, polarity, reset.
module tb_soc_system_lcd_touch_int_gen;
  localparam int GAP_CYCLES = 8;
  localparam int LIMIT      = 400;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        out_port;

  int n_cmp = 0;
  int n_bad = 0;

  soc_system_lcd_touch_int_gen #(
    .WIDTH_W    (16),
    .PEND_W     (4),
    .GAP_CYCLES (GAP_CYCLES),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
    $display("check %-14s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // Counts idle-level samples before the next pulse, then the active samples of that pulse.
  task automatic measure(input logic act, output int w, output int gap);
    gap = 0;
    w   = 0;
    while (out_port !== act && gap < LIMIT) begin
      gap++;
      @(negedge clk);
    end
    while (out_port === act && w < LIMIT) begin
      w++;
      @(negedge clk);
    end
  endtask

  logic [31:0] d;
  int w, g;

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;

    // 1: reset state
    repeat (2) @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_out_port", {31'b0, out_port}, 32'h1);
    check("rst_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    rd(2'd0, d); check("rst_ctrl", d, 32'h2);
    rd(2'd1, d); check("rst_width", d, 32'h1);

    // 2: single 5-cycle low pulse, done and irq, then clear
    wr(2'd1, 32'd5);
    wr(2'd2, 32'd1);
    wr(2'd0, 32'd3);
    wr(2'd3, 32'd1);
    measure(1'b0, w, g);
    check("t2_width", w, 32'd5);
    check("t2_irq_set", {31'b0, irq}, 32'h1);
    rd(2'd3, d); check("t2_done", d, 32'h1);
    wr(2'd3, 32'd2);
    check("t2_irq_clr", {31'b0, irq}, 32'h0);

    // 3: three queued 3-cycle pulses; idle spacing is the gap plus the re-arm cycle
    wr(2'd0, 32'd2);
    wr(2'd1, 32'd3);
    repeat (3) wr(2'd3, 32'd1);
    rd(2'd0, d); check("t3_pend3", d, 32'h302);
    wr(2'd0, 32'd3);
    measure(1'b0, w, g); check("t3_w1", w, 32'd3);
    measure(1'b0, w, g); check("t3_w2", w, 32'd3);
    check("t3_gap2", g, GAP_CYCLES + 1);
    measure(1'b0, w, g); check("t3_w3", w, 32'd3);
    check("t3_gap3", g, GAP_CYCLES + 1);
    repeat (12) @(negedge clk);
    rd(2'd0, d); check("t3_pend0", d, 32'h3);

    // 4: saturation and overflow, then drain 15 pulses
    wr(2'd0, 32'd2);
    wr(2'd3, 32'd2);
    rd(2'd3, d); check("t4_clr", d, 32'h0);
    repeat (16) wr(2'd3, 32'd1);
    rd(2'd0, d); check("t4_pend15", d, 32'hF02);
    rd(2'd3, d); check("t4_ovf", d, 32'h2);
    wr(2'd0, 32'd3);
    for (int i = 0; i < 15; i++) begin
      measure(1'b0, w, g);
      check($sformatf("t4_w%0d", i), w, 32'd3);
    end
    repeat (12) @(negedge clk);
    rd(2'd0, d); check("t4_drained", d, 32'h3);
    rd(2'd3, d); check("t4_done_ovf", d, 32'h3);

    // 5: abort a 100-cycle pulse at cycle 40
    wr(2'd3, 32'd2);
    wr(2'd1, 32'd100);
    wr(2'd3, 32'd1);
    wr(2'd3, 32'd1);
    g = 0;
    while (out_port !== 1'b0 && g < LIMIT) begin
      g++;
      @(negedge clk);
    end
    repeat (39) @(negedge clk);
    check("t5_still_low", {31'b0, out_port}, 32'h0);
    wr(2'd0, 32'd2);
    check("t5_abort_high", {31'b0, out_port}, 32'h1);
    rd(2'd0, d); check("t5_ctrl", d, 32'h2);
    rd(2'd3, d); check("t5_no_done", d, 32'h0);

    // 6: width 0, polarity swap, asynchronous reset mid-pulse
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd3);
    wr(2'd3, 32'd1);
    measure(1'b0, w, g); check("t6_w0_low", w, 32'd1);
    wr(2'd0, 32'd1);
    check("t6_idle_low", {31'b0, out_port}, 32'h0);
    wr(2'd3, 32'd1);
    measure(1'b1, w, g); check("t6_w0_high", w, 32'd1);
    wr(2'd0, 32'd3);
    check("t6_idle_high", {31'b0, out_port}, 32'h1);
    wr(2'd1, 32'd10);
    wr(2'd3, 32'd1);
    g = 0;
    while (out_port !== 1'b0 && g < LIMIT) begin
      g++;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("t6_mid_low", {31'b0, out_port}, 32'h0);
    #2 reset_n = 1'b0;
    #1 check("t6_async_rst", {31'b0, out_port}, 32'h1);
    @(negedge clk);
    check("t6_rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;
    rd(2'd0, d); check("t6_ctrl", d, 32'h2);
    repeat (15) @(negedge clk);
    check("t6_stays_idle", {31'b0, out_port}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
